// File: rtl/shift_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_arb_if
// Purpose  : Bundles the shift_arb request, config and output signals.
//            master = requester/controller/sink side, slave = shift_arb.
// Revision : 1.0  initial release
// ============================================================================
interface shift_arb_if #(
  parameter int IN_WIDTH   = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int SHFT_WIDTH = 4,
  parameter int N_REQ      = 4,
  parameter int IDX_W      = $clog2(N_REQ)
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*IN_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]          req_ready;
  logic                      cfg_we;
  logic [IDX_W-1:0]          cfg_idx;
  logic [SHFT_WIDTH-1:0]     cfg_shift;
  logic                      cfg_err;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]          out_src;

  modport master (
    output req_valid, req_data, cfg_we, cfg_idx, cfg_shift, out_ready,
    input  req_ready, cfg_err, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, cfg_we, cfg_idx, cfg_shift, out_ready,
    output req_ready, cfg_err, out_valid, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/shift_arb.sv
`default_nettype none
// ============================================================================
// Module   : shift_arb
// Purpose  : Round-robin arbiter over accumulator columns that right-aligns
//            the granted word by a per-column shift and registers an
//            OUT_WIDTH window behind a valid/ready output.
// Options  : SHIFT_ARB_SAT_EN - signed saturation of the output window.
// Revision : 1.0  initial release
// ============================================================================
module shift_arb #(
  parameter int IN_WIDTH   = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int SHFT_WIDTH = 4,
  parameter int N_REQ      = 4,
  parameter int IDX_W      = $clog2(N_REQ)
) (
  input  logic       clk,
  input  logic       rst_n,
  shift_arb_if.slave bus
);
  localparam int MAX_SHIFT = IN_WIDTH - OUT_WIDTH;

  logic [SHFT_WIDTH-1:0] shift_tbl_q [N_REQ];
  logic                  cfg_err_q;
  logic                  cfg_bad;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_src_q, out_src_d;

  logic                  load;
  logic                  grant_vld;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  int                    scan_idx;
  logic [N_REQ-1:0]      grant_oh;
  logic [IN_WIDTH-1:0]   word;
  logic [SHFT_WIDTH-1:0] shift;
  logic [IN_WIDTH-1:0]   shifted;
  logic [OUT_WIDTH-1:0]  slice;
  logic [OUT_WIDTH-1:0]  res;

  // The output register may take a new word when empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

  // Search for the first valid column starting at the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      cand = IDX_W'(scan_idx);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Ready is withheld during reset so no handshake can slip through.
  assign grant_oh = (rst_n && load && grant_vld)
                  ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

  // Mux the granted column's word and its currently stored shift.
  always_comb begin
    word  = '0;
    shift = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        word  = bus.req_data[i*IN_WIDTH +: IN_WIDTH];
        shift = shift_tbl_q[i];
      end
    end
  end

  // Shift s selects in[IN_WIDTH-1-s : IN_WIDTH-OUT_WIDTH-s].
  assign shifted = word >> (MAX_SHIFT - int'(shift));
  assign slice   = shifted[OUT_WIDTH-1:0];

`ifdef SHIFT_ARB_SAT_EN
  logic ovf;
  // Clamp when the discarded upper bits and the window MSB disagree.
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if ((i >= IN_WIDTH - 1 - int'(shift)) && (word[i] != word[IN_WIDTH-1]))
        ovf = 1'b1;
    end
    if (ovf)
      res = word[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                             : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else
      res = slice;
  end
`else
  assign res = slice;
`endif

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = res;
        out_src_d  = grant_idx;
        ptr_d      = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  // Output register and pointer; reset drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  // Out-of-range index or shift leaves the table untouched and flags an error.
  assign cfg_bad = ({1'b0, bus.cfg_idx} >= (IDX_W+1)'(N_REQ))
                || (int'(bus.cfg_shift) > MAX_SHIFT);

  // Shift table writes; a same-cycle grant still reads the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) shift_tbl_q[i] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && cfg_bad;
      if (bus.cfg_we && !cfg_bad) shift_tbl_q[bus.cfg_idx] <= bus.cfg_shift;
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arb
// Purpose  : Directed self-checking bench for shift_arb (default parameters).
//            Saturation expectations follow SHIFT_ARB_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_arb;
  localparam int IN_WIDTH   = 20;
  localparam int OUT_WIDTH  = 8;
  localparam int SHFT_WIDTH = 4;
  localparam int N_REQ      = 4;
  localparam int IDX_W      = 2;

`ifdef SHIFT_ARB_SAT_EN
  localparam logic [7:0] EXP_POS = 8'h7F;
  localparam logic [7:0] EXP_NEG = 8'h80;
`else
  localparam logic [7:0] EXP_POS = 8'hFF;
  localparam logic [7:0] EXP_NEG = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  shift_arb_if #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHFT_WIDTH(SHFT_WIDTH),
    .N_REQ(N_REQ), .IDX_W(IDX_W)
  ) bus ();

  shift_arb #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHFT_WIDTH(SHFT_WIDTH),
    .N_REQ(N_REQ), .IDX_W(IDX_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_col(input int i, input logic [IN_WIDTH-1:0] val);
    bus.req_data[i*IN_WIDTH +: IN_WIDTH] = val;
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [SHFT_WIDTH-1:0] s);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = idx;
    bus.cfg_shift = s;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  int         exp_src  [5] = '{2, 3, 0, 1, 2};
  logic [7:0] exp_data [5] = '{8'hCD, 8'h5E, 8'hAB, 8'h12, 8'hCD};

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_shift = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_src",   bus.out_src,   0);
    check("rst_cfg_err",   bus.cfg_err,   0);
    check("rst_req_ready", bus.req_ready, 0);
    bus.req_valid = 4'hF;
    #1;
    check("rst_req_ready_valid", bus.req_ready, 0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Single column with shift 4
    cfg_write(2'd1, 4'd4);
    check("cfg_ok_err", bus.cfg_err, 0);
    set_col(1, 20'h01230);
    bus.req_valid = 4'b0010;
    #1;
    check("t1_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    check("t1_valid", bus.out_valid, 1);
    check("t1_data",  bus.out_data,  8'h12);
    check("t1_src",   bus.out_src,   1);
    #1;
    check("t1_idle_ready", bus.req_ready, 0);
    tick();
    check("t1_drain_valid", bus.out_valid, 0);

    // Round robin, pointer starts at 2 after the col1 grant
    set_col(0, 20'hAB000);
    set_col(2, 20'hCD000);
    set_col(3, 20'h5E000);
    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_ready", bus.req_ready, 32'(1) << exp_src[k]);
      tick();
      check("rr_valid", bus.out_valid, 1);
      check("rr_src",   bus.out_src,   exp_src[k]);
      check("rr_data",  bus.out_data,  exp_data[k]);
    end

    // Backpressure holds the word and blocks grants
    bus.out_ready = 1'b0;
    #1;
    check("bp_ready0", bus.req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_data",  bus.out_data,  8'hCD);
      check("bp_src",   bus.out_src,   2);
      check("bp_ready", bus.req_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.req_ready, 4'b1000);
    tick();
    check("bp_next_src",  bus.out_src,  3);
    check("bp_next_data", bus.out_data, 8'h5E);
    bus.req_valid = '0;
    tick();
    check("bp_drain_valid", bus.out_valid, 0);

    // Illegal shift rejected, boundary shift accepted
    cfg_write(2'd0, 4'd13);
    check("cfg_bad_err", bus.cfg_err, 1);
    tick();
    check("cfg_bad_err_pulse", bus.cfg_err, 0);
    cfg_write(2'd3, 4'd12);
    check("cfg_max_err", bus.cfg_err, 0);
    bus.req_valid = 4'b0001;
    tick();
    check("cfg_bad_col0_data", bus.out_data, 8'hAB);
    check("cfg_bad_col0_src",  bus.out_src,  0);
    bus.req_valid = '0;
    tick();
    set_col(3, 20'h000AB);
    bus.req_valid = 4'b1000;
    #1;
    check("s12_ready", bus.req_ready, 4'b1000);
    tick();
    check("s12_data", bus.out_data, 8'hAB);
    check("s12_src",  bus.out_src,  3);
    bus.req_valid = '0;
    tick();

    // Same-cycle write and grant on col2
    bus.req_valid = 4'b0100;
    cfg_write(2'd2, 4'd2);
    check("wr_grant_old", bus.out_data, 8'hCD);
    check("wr_grant_src", bus.out_src,  2);
    tick();
    check("wr_grant_new", bus.out_data, 8'h34);
    bus.req_valid = '0;
    tick();

    // Overflow behaviour at shift 4 on col1
    set_col(1, 20'h7FFFF);
    bus.req_valid = 4'b0010;
    tick();
    check("sat_pos", bus.out_data, EXP_POS);
    set_col(1, 20'h80000);
    tick();
    check("sat_neg", bus.out_data, EXP_NEG);
    set_col(1, 20'hFFF80);
    tick();
    check("sat_none", bus.out_data, 8'hFF);
    bus.req_valid = '0;
    tick();

    // Reset mid-stream drops the word and clears pointer and table
    bus.req_valid = 4'hF;
    tick();
    check("mid_valid_pre", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data",  bus.out_data,  0);
    check("mid_rst_src",   bus.out_src,   0);
    check("mid_rst_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_ptr_reset", bus.req_ready, 4'b0001);
    set_col(1, 20'h01230);
    bus.req_valid = 4'b0010;
    tick();
    check("mid_tbl_reset_data", bus.out_data, 8'h01);
    check("mid_tbl_reset_src",  bus.out_src,  1);
    bus.req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
